// File: rtl/led_pattern_gen_pkg.sv
// Shared types for the LED pattern sequencer: pattern modes and bounce direction.
package led_pattern_gen_pkg;

  typedef enum logic [1:0] {
    MODE_BLINK  = 2'd0,
    MODE_CHASE  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_COUNT  = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

endpackage

// File: rtl/led_pattern_gen_prescaler.sv
// Step prescaler: counts enabled clk_x1 cycles and raises tick on the last one of each period.
module led_pattern_gen_prescaler
  import led_pattern_gen_pkg::*;
#(
  parameter int PERIOD = 12_000_000
) (
  input  logic i_clk_x1,
  input  logic i_rst,
  input  logic i_en,
  output logic o_tick
);

  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == CNT_LAST);

  // en=0 freezes the count so a resumed step keeps its partial progress
  always_ff @(posedge i_clk_x1 or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (o_tick) r_cnt <= '0;
      else        r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern sequencer: blink/chase/bounce/count advanced once per prescaler tick.
// state (cur_mode) | meaning
//   BLINK  | pat ^= blink_mask per tick
//   CHASE  | single lit bit rotates left
//   BOUNCE | single lit bit walks up/down, reversing at the ends
//   COUNT  | pat increments modulo 2^LED_W
module led_pattern_gen
  import led_pattern_gen_pkg::*;
#(
  parameter int LED_W      = 8,
  parameter int PERIOD     = 12_000_000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic             i_clk_x1,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [1:0]       i_mode,
  input  logic [LED_W-1:0] i_blink_mask,
  output logic [LED_W-1:0] o_led,
  output logic             o_step
);

  localparam logic [LED_W-1:0] PAT_ONE  = LED_W'(1);
  localparam logic [LED_W-1:0] PAT_TWO  = LED_W'(2);
  localparam logic [LED_W-1:0] PAT_SUB  = PAT_ONE << (LED_W - 2);
  localparam logic [LED_W-1:0] LED_RST  = ACTIVE_LOW ? {LED_W{1'b1}} : {LED_W{1'b0}};

  mode_t            r_cur_mode, w_cur_mode_nxt;
  dir_t             r_dir, w_dir_nxt;
  logic [LED_W-1:0] r_pat, w_pat_nxt;
  logic [LED_W-1:0] r_led;
  logic             r_step;
  logic             w_tick;
  logic             w_onehot;
  mode_t            w_mode_in;

  led_pattern_gen_prescaler #(
    .PERIOD (PERIOD)
  ) u_prescaler (
    .i_clk_x1 (i_clk_x1),
    .i_rst    (i_rst),
    .i_en     (i_en),
    .o_tick   (w_tick)
  );

  function automatic logic [LED_W-1:0] f_seed(input mode_t m);
    if (m == MODE_CHASE || m == MODE_BOUNCE) return PAT_ONE;
    else                                     return '0;
  endfunction

  assign w_mode_in = mode_t'(i_mode);
  assign w_onehot  = (r_pat != '0) && ((r_pat & (r_pat - PAT_ONE)) == '0);

  always_ff @(posedge i_clk_x1 or posedge i_rst) begin
    if (i_rst) begin
      r_cur_mode <= MODE_BLINK;
      r_dir      <= DIR_UP;
      r_pat      <= '0;
      r_led      <= LED_RST;
      r_step     <= 1'b0;
    end else begin
      r_cur_mode <= w_cur_mode_nxt;
      r_dir      <= w_dir_nxt;
      r_pat      <= w_pat_nxt;
      r_step     <= w_tick;
      if (w_tick) r_led <= ACTIVE_LOW ? ~w_pat_nxt : w_pat_nxt;
    end
  end

  always_comb begin
    w_cur_mode_nxt = r_cur_mode;
    w_dir_nxt      = r_dir;
    w_pat_nxt      = r_pat;
    if (w_tick) begin
      if (w_mode_in != r_cur_mode) begin
        w_cur_mode_nxt = w_mode_in;
        w_pat_nxt      = f_seed(w_mode_in);
        w_dir_nxt      = DIR_UP;
      end else begin
        unique case (r_cur_mode)
          MODE_BLINK: w_pat_nxt = r_pat ^ i_blink_mask;
          MODE_CHASE: begin
            if (!w_onehot) begin
              w_pat_nxt = PAT_ONE;
              w_dir_nxt = DIR_UP;
            end else begin
              w_pat_nxt = {r_pat[LED_W-2:0], r_pat[LED_W-1]};
            end
          end
          MODE_BOUNCE: begin
            // reversal and the first step back happen on the same tick: no dwell at the ends
            if (!w_onehot) begin
              w_pat_nxt = PAT_ONE;
              w_dir_nxt = DIR_UP;
            end else if (r_dir == DIR_UP) begin
              if (r_pat[LED_W-1]) begin
                w_pat_nxt = PAT_SUB;
                w_dir_nxt = DIR_DOWN;
              end else begin
                w_pat_nxt = r_pat << 1;
              end
            end else begin
              if (r_pat[0]) begin
                w_pat_nxt = PAT_TWO;
                w_dir_nxt = DIR_UP;
              end else begin
                w_pat_nxt = r_pat >> 1;
              end
            end
          end
          MODE_COUNT: w_pat_nxt = r_pat + PAT_ONE;
          default:    w_pat_nxt = r_pat;
        endcase
      end
    end
  end

  assign o_led  = r_led;
  assign o_step = r_step;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with LED_W=4, PERIOD=4, ACTIVE_LOW=1.
module tb_led_pattern_gen;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [3:0] mask;
  logic [3:0] led;
  logic       step;

  int total = 0;
  int bad   = 0;

  led_pattern_gen #(
    .LED_W      (4),
    .PERIOD     (4),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .i_clk_x1     (clk),
    .i_rst        (rst),
    .i_en         (en),
    .i_mode       (mode),
    .i_blink_mask (mask),
    .o_led        (led),
    .o_step       (step)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] md, input logic [3:0] msk);
    @(posedge clk);
    #1;
    rst  = 1'b1;
    en   = 1'b1;
    mode = md;
    mask = msk;
    #2;
    check("rst led", int'(led), 32'hF);
    check("rst step", int'(step), 0);
    rst = 1'b0;
  endtask

  // waits for the next step pulse, checks its distance in edges and the pattern shown
  task automatic step_and_check(input string tag, input logic [3:0] exp_pat, input int exp_cyc);
    int n;
    logic [3:0] exp_led;
    n = 0;
    exp_led = ~exp_pat;
    do begin
      next_edge();
      n++;
    end while (step !== 1'b1 && n < 20);
    check({tag, " cyc"}, n, exp_cyc);
    check({tag, " led"}, int'(led), int'(exp_led));
  endtask

  logic [3:0] chase_exp  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] bounce_exp [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                 4'b0100, 4'b0010, 4'b0001, 4'b0010};

  initial begin
    clk  = 1'b0;
    rst  = 1'b1;
    en   = 1'b0;
    mode = 2'd0;
    mask = 4'b0000;
    #12;
    check("init led", int'(led), 32'hF);
    check("init step", int'(step), 0);

    // reset and prescaler timing in BLINK
    do_reset(2'd0, 4'b0011);
    for (int k = 1; k <= 3; k++) begin
      next_edge();
      check($sformatf("pre%0d led", k), int'(led), 32'hF);
      check($sformatf("pre%0d step", k), int'(step), 0);
    end
    next_edge();
    check("blink1 led", int'(led), 32'hC);
    check("blink1 step", int'(step), 1);
    for (int k = 1; k <= 3; k++) begin
      next_edge();
      check($sformatf("gap%0d led", k), int'(led), 32'hC);
      check($sformatf("gap%0d step", k), int'(step), 0);
    end
    next_edge();
    check("blink2 led", int'(led), 32'hF);
    check("blink2 step", int'(step), 1);
    mask = 4'b0000;
    step_and_check("blink_zero", 4'b0000, 4);

    // chase
    do_reset(2'd1, 4'b0000);
    for (int i = 0; i < 5; i++)
      step_and_check($sformatf("chase%0d", i), chase_exp[i], 4);

    // bounce
    do_reset(2'd2, 4'b0000);
    for (int i = 0; i < 8; i++)
      step_and_check($sformatf("bounce%0d", i), bounce_exp[i], 4);

    // count with wrap on the 17th tick
    do_reset(2'd3, 4'b0000);
    for (int i = 0; i < 17; i++) begin
      logic [3:0] v;
      v = 4'(i % 16);
      step_and_check($sformatf("count%0d", i), v, 4);
    end

    // hold at cnt=2
    do_reset(2'd0, 4'b0011);
    next_edge();
    next_edge();
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      next_edge();
      check($sformatf("hold%0d led", k), int'(led), 32'hF);
      check($sformatf("hold%0d step", k), int'(step), 0);
    end
    en = 1'b1;
    step_and_check("resume", 4'b0011, 2);

    // mode switch CHASE->COUNT at cnt=1
    do_reset(2'd1, 4'b0000);
    step_and_check("sw_chase", 4'b0001, 4);
    next_edge();
    mode = 2'd3;
    step_and_check("sw_seed", 4'b0000, 3);
    step_and_check("sw_cnt1", 4'b0001, 4);
    step_and_check("sw_cnt2", 4'b0010, 4);

    // async reset while step is high, between clock edges
    #2;
    rst = 1'b1;
    #1;
    check("async led", int'(led), 32'hF);
    check("async step", int'(step), 0);
    next_edge();
    check("async hold led", int'(led), 32'hF);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
